// File: rtl/adpcm_main_mul_share_arb_if.sv
// adpcm_main_mul_share_arb_if
// Bundles the requester side and the response side of the shared-multiplier
// arbiter.
//
// Handshake: a beat moves on a rising clock edge when valid and ready are both
// high in the cycle before it. req_valid[i]/req_ready[i] form one channel per
// requester. rsp_valid/rsp_ready form the single response channel. A source
// must hold valid and its payload stable until it is accepted.
//
// Signals:
//   req_valid  [NUM_REQ]            per-requester operand valid
//   req_ready  [NUM_REQ]            per-requester accept, one-hot or zero
//   req_din0   [NUM_REQ*DIN_WIDTH]  operand 0, requester i at [i*DIN_WIDTH +: DIN_WIDTH]
//   req_din1   [NUM_REQ*DIN_WIDTH]  operand 1, same packing
//   rsp_valid                        product valid
//   rsp_ready                        consumer accepts the product
//   rsp_id     [ID_WIDTH]            requester that owns rsp_dout
//   rsp_dout   [DOUT_WIDTH]          truncated product
// Modports: master = requesters plus consumer, slave = arbiter.
interface adpcm_main_mul_share_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 15,
  parameter int DOUT_WIDTH = 29,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_din1;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_WIDTH-1:0]          rsp_id;
  logic [DOUT_WIDTH-1:0]        rsp_dout;

  modport master (
    output req_valid, req_din0, req_din1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dout
  );

  modport slave (
    input  req_valid, req_din0, req_din1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dout
  );
endinterface

// File: rtl/adpcm_main_mul_share_arb.sv
// adpcm_main_mul_share_arb
// Round-robin arbiter that time-shares one 15x15 unsigned multiplier among
// NUM_REQ requesters. Each cycle it grants at most one requester, multiplies
// its operands combinationally, and registers the truncated product together
// with the requester index.
//
// Ports:
//   ap_clk    rising-edge clock
//   ap_rst_n  asynchronous active-low reset
//   bus       adpcm_main_mul_share_arb_if.slave (request and response channels)
//   dbg_ptr   round-robin pointer (index of the last granted requester)
//
// Optional feature macro: ADPCM_MUL_ARB_OUTREG_EN
//   Undefined: the response comes from S1, one cycle after the accepting edge.
//   Defined:   a second stage S2 follows S1 and drives the response, two
//              cycles after the accepting edge, still one product per cycle.
module adpcm_main_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 15,
  parameter int DOUT_WIDTH = 29,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  adpcm_main_mul_share_arb_if.slave   bus,
  output logic [ID_WIDTH-1:0]         dbg_ptr
);

  logic [ID_WIDTH-1:0]   ptr;
  logic                  s1_valid;
  logic [ID_WIDTH-1:0]   s1_id;
  logic [DOUT_WIDTH-1:0] s1_dout;

  logic                  slot_free;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic                  xfer;
  logic [DIN_WIDTH-1:0]  mul_a;
  logic [DIN_WIDTH-1:0]  mul_b;
  logic [DOUT_WIDTH-1:0] mul_prod;

  // Scan upward from ptr+1, wrapping modulo NUM_REQ; the first valid wins.
  // Only req_valid and ptr feed this search, never operand values.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Grants are suppressed during reset so nothing is accepted and then lost.
  assign xfer          = ap_rst_n && slot_free && grant_found;
  assign bus.req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

  // Operand mux feeding the single shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        mul_a = bus.req_din0[i*DIN_WIDTH +: DIN_WIDTH];
        mul_b = bus.req_din1[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  // Full-width unsigned product, truncated to the low DOUT_WIDTH bits.
  assign mul_prod = DOUT_WIDTH'({{DIN_WIDTH{1'b0}}, mul_a} * {{DIN_WIDTH{1'b0}}, mul_b});

  // S1 and the round-robin pointer. When S1 can advance it either takes the
  // new product or empties; otherwise everything holds.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr      <= ID_WIDTH'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_dout  <= '0;
    end else if (slot_free) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_id   <= grant_idx;
        s1_dout <= mul_prod;
        ptr     <= grant_idx;
      end
    end
  end

`ifdef ADPCM_MUL_ARB_OUTREG_EN
  logic                  s2_valid;
  logic [ID_WIDTH-1:0]   s2_id;
  logic [DOUT_WIDTH-1:0] s2_dout;
  logic                  s2_take;

  // S2 accepts whenever it is empty or its content is being consumed.
  assign s2_take   = !s2_valid || bus.rsp_ready;
  // S1 may be refilled if it is empty or its content moves into S2 this edge.
  assign slot_free = !s1_valid || s2_take;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_dout  <= '0;
    end else if (s2_take) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id   <= s1_id;
        s2_dout <= s1_dout;
      end
    end
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_dout  = s2_dout;
`else
  assign slot_free     = !s1_valid || bus.rsp_ready;
  assign bus.rsp_valid = s1_valid;
  assign bus.rsp_id    = s1_id;
  assign bus.rsp_dout  = s1_dout;
`endif

  assign dbg_ptr = ptr;

endmodule

// File: tb/tb_adpcm_main_mul_share_arb.sv
// tb_adpcm_main_mul_share_arb
// Directed bench for adpcm_main_mul_share_arb: reset behaviour, single
// request, round-robin fairness, back-pressure, sparse requests with wrap,
// and asynchronous reset with a response in flight. Responses are checked
// against an expected queue by a monitor; grant vectors and held values are
// checked inline. Response latency follows ADPCM_MUL_ARB_OUTREG_EN.
module tb_adpcm_main_mul_share_arb;

  localparam int NR = 4;
  localparam int DW = 15;
  localparam int OW = 29;
  localparam int IW = 2;
`ifdef ADPCM_MUL_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  adpcm_main_mul_share_arb_if #(.NUM_REQ(NR), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .ID_WIDTH(IW)) bus ();
  logic [IW-1:0] dbg_ptr;

  adpcm_main_mul_share_arb #(.NUM_REQ(NR), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .ID_WIDTH(IW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave),
    .dbg_ptr  (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [IW+OW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [OW-1:0] dout);
    exp_q.push_back({IW'(id), dout});
  endtask

  // A response is consumed at the next rising edge whenever valid and ready
  // are both high; sample at the falling edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_spurious_valid", 32'(bus.rsp_valid), 32'd0);
      end else begin
        check("rsp_id_dout", 32'({bus.rsp_id, bus.rsp_dout}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_valid = bus.req_valid | (NR'(1) << i);
    bus.req_din0[i*DW +: DW] = a;
    bus.req_din1[i*DW +: DW] = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_empty(input string tag);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_reqs();
    bus.rsp_ready = 1'b1;

    // Reset: all requesters valid, nothing may be granted.
    bus.req_valid = '1;
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst_rsp_dout",  32'(bus.rsp_dout),  32'd0);
    check("rst_ptr",       32'(dbg_ptr),       32'd3);
    ap_rst_n = 1'b1;
    #1;
    check("rst_first_grant", 32'(bus.req_ready), 32'b0001);
    clear_reqs();
    tick();
    check("rst_no_xfer", 32'(bus.rsp_valid), 32'd0);

    // Single request: req 2, 0x7FFF * 0x7FFF = 0x3FFF0001 -> 0x1FFF0001.
    push_exp(2, 29'h1FFF0001);
    set_req(2, 15'h7FFF, 15'h7FFF);
    #1;
    check("single_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    clear_reqs();
    if (LAT == 2) begin
      check("single_lat2_empty", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    check("single_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_ptr", 32'(dbg_ptr), 32'd2);
    wait_empty("single_drained");

    // Fairness: all valid, din0=i+1, din1=3 -> ids 0,1,2,3,0,... products 3,6,9,12.
    do_reset();
    for (int k = 0; k < 8; k++) push_exp(k % NR, OW'(((k % NR) + 1) * 3));
    for (int i = 0; i < NR; i++) set_req(i, DW'(i + 1), 15'd3);
    for (int t = 1; t <= 8 + LAT - 1; t++) begin
      tick();
      if (t == 8) clear_reqs();
      if (t >= LAT) check("fair_back_to_back", 32'(bus.rsp_valid), 32'd1);
    end
    wait_empty("fair_drained");
    check("fair_ptr", 32'(dbg_ptr), 32'd3);

    // Back-pressure: fill the pipeline, then hold req 1 against rsp_ready=0.
    bus.rsp_ready = 1'b0;
    push_exp(0, 29'd6);
    if (LAT == 2) push_exp(2, 29'd20);
    push_exp(1, 29'd35);
    set_req(0, 15'd2, 15'd3);
    #1;
    check("bp_grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    clear_reqs();
    if (LAT == 2) begin
      set_req(2, 15'd4, 15'd5);
      #1;
      check("bp_grant2_fill", 32'(bus.req_ready), 32'b0100);
      tick();
      clear_reqs();
    end
    set_req(1, 15'd5, 15'd7);
    for (int h = 0; h < 5; h++) begin
      #1;
      check("bp_ready_low", 32'(bus.req_ready), 32'd0);
      check("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
      check("bp_id_stable", 32'(bus.rsp_id), 32'd0);
      check("bp_dout_stable", 32'(bus.rsp_dout), 32'd6);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    clear_reqs();
    wait_empty("bp_drained");
    check("bp_ptr", 32'(dbg_ptr), 32'd1);

    // Sparse: req 3 alone (wraps 2,3), then req 1 alone (wraps 0,1); zero operand.
    push_exp(3, 29'd0);
    push_exp(1, 29'h10000);
    set_req(3, 15'd0, 15'd9);
    #1;
    check("sparse_grant3", 32'(bus.req_ready), 32'b1000);
    tick();
    clear_reqs();
    set_req(1, 15'h100, 15'h100);
    #1;
    check("sparse_grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    clear_reqs();
    wait_empty("sparse_drained");
    check("sparse_ptr", 32'(dbg_ptr), 32'd1);

    // Mid-flight reset: response held with rsp_ready=0, then async reset.
    bus.rsp_ready = 1'b0;
    set_req(2, 15'd3, 15'd3);
    #1;
    check("mid_grant2", 32'(bus.req_ready), 32'b0100);
    tick();
    clear_reqs();
    if (LAT == 2) tick();
    check("mid_inflight", 32'(bus.rsp_valid), 32'd1);
    #2;
    ap_rst_n = 1'b0;
    bus.req_valid = '1;
    #1;
    check("mid_rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check("mid_rsp_dout_clear", 32'(bus.rsp_dout), 32'd0);
    check("mid_ptr_reset", 32'(dbg_ptr), 32'd3);
    check("mid_ready_in_reset", 32'(bus.req_ready), 32'd0);
    tick();
    ap_rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check("mid_regrant0", 32'(bus.req_ready), 32'b0001);
    clear_reqs();
    tick();
    tick();
    check("mid_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog: the directed sequence is short; this only fires on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
